mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the 8-bit unified RAM and the two 32-bit requesters: the instruction-fetch stage and the memory-access stage. Arbitrates one transaction at a time, serialises each 1/2/4-byte access into consecutive RAM byte cycles, assembles little-endian read words, and returns a one-cycle completion pulse. Removes the per-byte counter sequencing from the fetch stage, which issues one word request and waits for `if_done_o`.

## Interface

- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global run enable; low freezes the block.
- `if_req_i`  in  1  fetch request, level, held until `if_done_o`.
- `if_addr_i`  in  32  fetch byte address; always a 4-byte read.
- `if_data_o`  out  32  fetched instruction, valid while `if_done_o`=1.
- `if_done_o`  out  1  one-cycle fetch completion pulse.
- `mem_req_i`  in  1  load/store request, level, held until `mem_done_o`.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_len_i`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `mem_addr_i`  in  32  load/store byte address.
- `mem_wdata_i`  in  32  store data, byte 0 = bits [7:0].
- `mem_data_o`  out  32  load data, zero-extended, valid while `mem_done_o`=1.
- `mem_done_o`  out  1  one-cycle load/store completion pulse.
- `ram_addr_o`  out  32  RAM byte address.
- `ram_wr_o`  out  1  RAM write strobe.
- `ram_dout_o`  out  8  RAM write byte.
- `ram_din_i`  in  8  RAM read byte; data for the address presented in cycle t appears in cycle t+1.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE: at a rising edge with any request high, latch base address, length n (1/2/4), write data, and owner. `mem_req_i` has priority over `if_req_i`; the losing request stays pending and is served from the next IDLE.
- READ: byte counter k = 0..n-1; `ram_addr_o` = base + k in the k-th cycle after acceptance; byte k captured one cycle later into bits [8k+7:8k]. After the last capture → DONE. Unread upper bytes are 0.
- WRITE: `ram_wr_o`=1, `ram_addr_o` = base + k, `ram_dout_o` = wdata[8k+7:8k] for k = 0..n-1 in consecutive cycles → DONE.
- DONE: exactly one cycle; the owner's done pulses with its data; the other done stays 0; requests ignored; → IDLE. Requesters drop `req` upon seeing done.
- Address arithmetic is 32-bit modulo: base 0xFFFFFFFF, k=1 gives 0x00000000. No alignment check.
- Data outputs hold their last value outside DONE.
- `rdy`=0: no state, counter, or register changes; `ram_wr_o` forced to 0 combinationally; the RAM output register is also held by `rdy` at system level, so capture resumes correctly.
- `rst` low (any time, including mid-transaction): immediately return to IDLE, all outputs 0, no done pulse for the aborted access. Bytes already written stay written.

## Timing

- Edge E0 accepts. Reads: addresses in cycles after E0..E(n-1), captures at E2..E(n+1); done high in the cycle after E(n+1). Word read = 5 cycles accept-to-done; byte read = 2.
- Writes: bytes in cycles after E0..E(n-1); done high in the cycle after En. Word store = 4 cycles; byte store = 1.
- Back-to-back: the next acceptance occurs at the edge ending the IDLE cycle that follows DONE; minimum word-fetch throughput is 1 per 7 cycles.
- Reset values: `if_data_o`, `mem_data_o`, `ram_addr_o`, `ram_dout_o` = 0; `if_done_o`, `mem_done_o`, `ram_wr_o`, `busy_o` = 0.

## Test plan

- Fetch with RAM[0x100..0x103]=13,05,A0,00 and `if_req_i` at 0x100 -> addresses 0x100..0x103 in successive cycles; `if_done_o` pulses once, 5 cycles after accept, with `if_data_o`=0x00A00513.
- Simultaneous `if_req_i`@0x0 and load word @0x200 -> load served first (`mem_done_o` first), then fetch accepted after DONE+IDLE; each done is one cycle.
- Store half 0xBEEF @0x301 -> `ram_wr_o` for 2 cycles with (0x301,EF), (0x302,BE); `mem_done_o` after 2 cycles; a load byte @0x302 then returns 0x000000BE.
- Load word @0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- `rdy` low for 3 cycles mid word-read -> state frozen and `ram_wr_o`=0; the correct word is returned with latency stretched by 3; `rst` low mid-store -> all outputs 0 asynchronously, no done pulse, block is back in IDLE.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial controller: one 1/2/4-byte access at a time from fetch or load/store to an 8-bit RAM.
// Loads assemble little-endian words; stores emit one byte per cycle; done pulses for one cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rdata, rdata_nxt;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [2:0]  req_len;
    logic        owner_if;
    logic        accept;

    always_comb begin
        case (mem_len_i)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i || if_req_i) begin
                    accept    = 1'b1;
                    state_nxt = (mem_req_i && mem_we_i) ? WRITE : READ;
                end
            end
            // read data lags the address by a cycle, so READ runs one cycle past the last address
            READ:    if (cnt == len) state_nxt = DONE;
            WRITE:   if (cnt == len - 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // byte cnt-1 arrives on ram_din_i while cnt addresses the next byte
    always_comb begin
        rdata_nxt = rdata;
        case (cnt)
            3'd1:    rdata_nxt[7:0]   = ram_din_i;
            3'd2:    rdata_nxt[15:8]  = ram_din_i;
            3'd3:    rdata_nxt[23:16] = ram_din_i;
            3'd4:    rdata_nxt[31:24] = ram_din_i;
            default: rdata_nxt = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= 32'd0;
            wdata      <= 32'd0;
            rdata      <= 32'd0;
            cnt        <= 3'd0;
            len        <= 3'd0;
            owner_if   <= 1'b0;
            if_data_o  <= 32'd0;
            mem_data_o <= 32'd0;
        end else if (rdy) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base     <= mem_req_i ? mem_addr_i : if_addr_i;
                        len      <= mem_req_i ? req_len : 3'd4;
                        wdata    <= mem_wdata_i;
                        owner_if <= !mem_req_i;
                        cnt      <= 3'd0;
                        rdata    <= 32'd0;
                    end
                end
                READ: begin
                    cnt   <= cnt + 3'd1;
                    rdata <= rdata_nxt;
                    if (cnt == len) begin
                        if (owner_if) if_data_o  <= rdata_nxt;
                        else          mem_data_o <= rdata_nxt;
                    end
                end
                WRITE:   cnt <= cnt + 3'd1;
                default: ;
            endcase
        end
    end

    assign ram_addr_o = base + {29'd0, cnt};
    assign ram_wr_o   = (state == WRITE) && rdy;
    assign ram_dout_o = (state == WRITE) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign if_done_o  = (state == DONE) && owner_if;
    assign mem_done_o = (state == DONE) && !owner_if;
    assign busy_o     = (state != IDLE);
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl: a byte RAM answers the DUT, a separate reference memory
// predicts every address, write byte, done pulse and returned word.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_data;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;
    logic        busy;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_data_o(mem_data), .mem_done_o(mem_done),
        .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_data = 32'd0;
    logic [31:0] exp_mem_data = 32'd0;

    logic [7:0] ram_env [logic [31:0]];
    logic [7:0] ram_ref [logic [31:0]];

    function automatic logic [7:0] fill(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return ram_env.exists(a) ? ram_env[a] : fill(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ram_ref.exists(a) ? ram_ref[a] : fill(a);
    endfunction

    // registered-read RAM whose output register is also held by rdy
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= env_rd(ram_addr);
            if (ram_wr) ram_env[ram_addr] = ram_dout;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge, in an IDLE cycle with the request(s) already driven.
    // stall_mode: 0 none, 1 random rdy drops, 2 rdy low for 3 cycles once two bytes are under way.
    task automatic expect_txn(input bit is_if, input int stall_mode);
        logic [31:0] base, wd, exp_rd;
        bit          we, fin;
        int          n, dn, e, done_cyc;
        if (is_if) begin
            base = if_addr; we = 1'b0; n = 4; wd = 32'd0;
        end else begin
            base = mem_addr; we = mem_we; wd = mem_wdata;
            n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
        end
        dn = we ? n : n + 1;
        exp_rd = 32'd0;
        if (!we) for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_rd(base + 32'(k));
        rdy = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_done", {if_done, mem_done}, 2'b00);
        @(posedge clk); #1;
        e = 0; fin = 1'b0; done_cyc = -1;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            if (stall_mode == 1)      rdy = ($urandom_range(0, 3) != 0);
            else if (stall_mode == 2) rdy = !(cyc >= 2 && cyc < 5);
            else                      rdy = 1'b1;
            @(negedge clk);
            if (e == dn && !we) begin
                if (is_if) exp_if_data = exp_rd;
                else       exp_mem_data = exp_rd;
            end
            if (e == dn && done_cyc < 0) done_cyc = cyc;
            check_eq("busy", busy, 1'b1);
            check_eq("wr", ram_wr, we && e < n && rdy);
            if (e < n) begin
                check_eq("addr", ram_addr, base + 32'(e));
                if (we) check_eq("dout", ram_dout, wd[8*e +: 8]);
            end
            check_eq("if_done", if_done, (e == dn) && is_if);
            check_eq("mem_done", mem_done, (e == dn) && !is_if);
            check_eq("if_data", if_data, exp_if_data);
            check_eq("mem_data", mem_data, exp_mem_data);
            if (we && e < n && rdy) ram_ref[base + 32'(e)] = wd[8*e +: 8];
            @(posedge clk); #1;
            if (rdy) begin
                if (e == dn) fin = 1'b1;
                e++;
            end
        end
        check_eq("end", e, dn + 1);
        if (stall_mode == 0) check_eq("latency", done_cyc, dn);
        if (stall_mode == 2) check_eq("latency_stall", done_cyc, dn + 3);
        if (is_if) if_req = 1'b0;
        else       mem_req = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic set_mem(input bit we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    endtask

    task automatic set_if(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_if_data", if_data, 32'd0);
        check_eq("rst_mem_data", mem_data, 32'd0);
        check_eq("rst_ram_addr", ram_addr, 32'd0);
        check_eq("rst_ram_dout", ram_dout, 8'd0);
        check_eq("rst_ctrl", {if_done, mem_done, ram_wr, busy}, 4'd0);
        rst = 1'b1;

        // instruction fetch from known bytes
        for (int k = 0; k < 4; k++) begin
            a = 32'h100 + 32'(k);
            ram_env[a] = (k == 0) ? 8'h13 : (k == 1) ? 8'h05 : (k == 2) ? 8'hA0 : 8'h00;
            ram_ref[a] = ram_env[a];
        end
        set_if(32'h100);
        expect_txn(1'b1, 0);
        check_eq("fetch_word", if_data, 32'h00A00513);

        // simultaneous requests: load wins, fetch follows
        set_if(32'h0);
        set_mem(1'b0, 2'b10, 32'h200, 32'd0);
        expect_txn(1'b0, 0);
        expect_txn(1'b1, 0);

        // store half then load the upper byte back
        set_mem(1'b1, 2'b01, 32'h301, 32'h0000BEEF);
        expect_txn(1'b0, 0);
        set_mem(1'b0, 2'b00, 32'h302, 32'd0);
        expect_txn(1'b0, 0);
        check_eq("load_be", mem_data, 32'h000000BE);

        // address wrap
        set_mem(1'b0, 2'b10, 32'hFFFFFFFE, 32'd0);
        expect_txn(1'b0, 0);

        // three-cycle freeze mid word read
        set_mem(1'b0, 2'b11, 32'h101, 32'd0);
        expect_txn(1'b0, 2);
        set_if(32'h1FE);
        expect_txn(1'b1, 2);

        // reset mid word store: two bytes land, no done
        set_mem(1'b1, 2'b10, 32'h400, 32'hCAFEF00D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_eq("arst_data", {if_data, mem_data}, 64'd0);
        check_eq("arst_ram", {ram_addr, ram_dout}, 40'd0);
        check_eq("arst_ctrl", {if_done, mem_done, ram_wr, busy}, 4'd0);
        ram_ref[32'h400] = 8'h0D;
        ram_ref[32'h401] = 8'hF0;
        exp_if_data = 32'd0;
        exp_mem_data = 32'd0;
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst", {if_done, mem_done, busy}, 3'd0);
        end
        @(posedge clk); #1;
        set_mem(1'b0, 2'b10, 32'h400, 32'd0);
        expect_txn(1'b0, 0);

        // randomized traffic over a small window plus the top of the address space
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 2);
            a = (($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : 32'h500) + 32'($urandom_range(0, 15));
            if (r != 1) set_if(a);
            if (r != 0) set_mem($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                                (($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : 32'h500) + 32'($urandom_range(0, 15)),
                                $urandom);
            if (r != 0) expect_txn(1'b0, $urandom_range(0, 1));
            if (r != 1) expect_txn(1'b1, $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
